branch_unit_bht: RTL and testbench

//  Next-generation control-transfer unit for the multicycle RISC-V core. It resolves all six

---
 rtl/riscv_pkg.sv | 32 +++
 rtl/branch_unit_bht_sat_counter.sv | 34 +++
 rtl/branch_unit_bht.sv | 130 +++++++++++++
 tb/tb_branch_unit_bht.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V control encodings and saturating-arithmetic helpers.
package riscv_pkg;

    // Branch funct3 encodings (010 and 011 are unused and treated as illegal).
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // PC-source selection coming from the control FSM.
    typedef enum logic [1:0] {
        ORIGPC_NORMAL = 2'b00,
        ORIGPC_BRANCH = 2'b01,
        ORIGPC_JAL    = 2'b10,
        ORIGPC_JALR   = 2'b11
    } origPc_e;

    // Increment a w-bit value (carried in 64 bits), holding at all-ones.
    function automatic logic [63:0] sat_inc(input logic [63:0] value, input int unsigned w);
        logic [63:0] maxVal;
        maxVal = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        return (value >= maxVal) ? maxVal : value + 64'd1;
    endfunction

    // Decrement a value, holding at zero.
    function automatic logic [63:0] sat_dec(input logic [63:0] value);
        return (value == 64'd0) ? 64'd0 : value - 64'd1;
    endfunction

endpackage

// File: rtl/branch_unit_bht_sat_counter.sv
// Generic W-bit up/down saturating counter with a configurable reset value.
import riscv_pkg::*;

module sat_counter #(
    parameter int unsigned W       = 2,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         iCLK,
    input  logic         iRST_n,
    input  logic         iInc,
    input  logic         iDec,
    output logic [W-1:0] oCount
);

    logic [W-1:0] cntQ;
    logic [63:0]  cntWide;

    assign cntWide = 64'(cntQ);

    // Count register: step up or down by one, clamped at both ends; simultaneous inc/dec holds.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
        if (!iRST_n) begin
            cntQ <= RST_VAL;
        end else if (iInc && !iDec) begin
            cntQ <= W'(sat_inc(cntWide, W));
        end else if (iDec && !iInc) begin
            cntQ <= W'(sat_dec(cntWide));
        end
    end

    assign oCount = cntQ;

endmodule

// File: rtl/branch_unit_bht.sv
// Control-transfer unit: branch/jump resolution, direct-mapped BHT prediction,
// misprediction detection and saturating performance counters.
import riscv_pkg::*;

module branch_unit_bht #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned BHT_ENTRIES = 16,
    parameter int unsigned CNT_W       = 2,
    parameter int unsigned PERF_W      = 32
) (
    input  logic              iCLK,
    input  logic              iRST_n,
    input  logic [XLEN-1:0]   iFetchPC,
    output logic              oPredTaken,
    input  logic              iResolveValid,
    input  logic [XLEN-1:0]   iResolvePC,
    input  logic              iPredTaken,
    input  logic [2:0]        iFunct3,
    input  logic [1:0]        iCOrigPC,
    input  logic              iZero,
    input  logic              iLT,
    input  logic              iLTU,
    output logic              oCTransf,
    output logic              oMispredict,
    output logic              oBrIllegal,
    output logic [PERF_W-1:0] oBranchCnt,
    output logic [PERF_W-1:0] oMispredCnt
);

    localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);
    // Weakly-not-taken: MSB clear, all lower bits set (zero for a 1-bit counter).
    localparam logic [CNT_W-1:0] WEAK_NT = CNT_W'((64'd1 << (CNT_W - 1)) - 64'd1);

    // Branch condition from ALU compare flags; reserved funct3 values never take.
    function automatic logic evalCond(input logic [2:0] f3, input logic zero,
                                      input logic lt, input logic ltu);
        case (f3)
            F3_BEQ:  return zero;
            F3_BNE:  return !zero;
            F3_BLT:  return lt;
            F3_BGE:  return !lt;
            F3_BLTU: return ltu;
            F3_BGEU: return !ltu;
            default: return 1'b0;
        endcase
    endfunction

    logic [IDX_W-1:0] fetchIdx;
    logic [IDX_W-1:0] resolveIdx;
    logic             isBranch;
    logic             legalF3;
    logic             branchTaken;
    logic             doUpdate;
    logic             mismatch;
    logic             mispredictQ;
    logic             brIllegalQ;
    logic [CNT_W-1:0] bhtCnt [BHT_ENTRIES];
    logic             unusedPcBits;

    // Word-aligned index; low two PC bits and bits above the index are ignored (no tags).
    assign fetchIdx     = iFetchPC[IDX_W+1:2];
    assign resolveIdx   = iResolvePC[IDX_W+1:2];
    assign unusedPcBits = ^{iFetchPC[1:0], iResolvePC[1:0],
                            iFetchPC[XLEN-1:IDX_W+2], iResolvePC[XLEN-1:IDX_W+2]};

    assign isBranch    = (iCOrigPC == ORIGPC_BRANCH);
    assign legalF3     = (iFunct3 != 3'b010) && (iFunct3 != 3'b011);
    assign branchTaken = evalCond(iFunct3, iZero, iLT, iLTU);
    assign doUpdate    = iResolveValid && isBranch && legalF3;
    assign mismatch    = (branchTaken != iPredTaken);

    // PC-source decision, independent of the resolve strobe.
    always_comb begin
        // NOTE: default first so every path assigns oCTransf and no latch is inferred.
        oCTransf = 1'b0;
        case (iCOrigPC)
            ORIGPC_BRANCH:             oCTransf = branchTaken;
            ORIGPC_JAL, ORIGPC_JALR:   oCTransf = 1'b1;
            default:                   oCTransf = 1'b0;
        endcase
    end

    // BHT: one saturating counter per entry, trained only by legal resolved branches.
    // NOTE: the table is built from resettable flops because reset must force weakly-not-taken.
    for (genvar i = 0; i < BHT_ENTRIES; i++) begin : gBht
        logic hit;
        assign hit = doUpdate && (resolveIdx == IDX_W'(i));
        sat_counter #(.W(CNT_W), .RST_VAL(WEAK_NT)) uEntry (
            .iCLK   (iCLK),
            .iRST_n (iRST_n),
            .iInc   (hit && branchTaken),
            .iDec   (hit && !branchTaken),
            .oCount (bhtCnt[i])
        );
    end

    // Lookup sees the pre-edge table contents; a same-cycle update is not bypassed.
    assign oPredTaken = bhtCnt[fetchIdx][CNT_W-1];

    sat_counter #(.W(PERF_W), .RST_VAL('0)) uBranchCnt (
        .iCLK   (iCLK),
        .iRST_n (iRST_n),
        .iInc   (doUpdate),
        .iDec   (1'b0),
        .oCount (oBranchCnt)
    );

    sat_counter #(.W(PERF_W), .RST_VAL('0)) uMispredCnt (
        .iCLK   (iCLK),
        .iRST_n (iRST_n),
        .iInc   (doUpdate && mismatch),
        .iDec   (1'b0),
        .oCount (oMispredCnt)
    );

    // One-cycle status pulses for the resolve seen on the previous edge.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            mispredictQ <= 1'b0;
            brIllegalQ  <= 1'b0;
        end else begin
            mispredictQ <= doUpdate && mismatch;
            brIllegalQ  <= iResolveValid && isBranch && !legalF3;
        end
    end

    assign oMispredict = mispredictQ;
    assign oBrIllegal  = brIllegalQ;

endmodule

// File: tb/tb_branch_unit_bht.sv
// Self-checking bench for branch_unit_bht: directed scenarios plus random traffic
// compared every cycle against a behavioural model. A second instance uses 4-bit
// performance counters so saturation is reachable.
module tb_branch_unit_bht;

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic [31:0] fetchPc = '0;
    logic [31:0] resolvePc = '0;
    logic        resolveValid = 1'b0;
    logic        predIn = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [1:0]  cOrigPc = '0;
    logic        zero = 1'b0, lt = 1'b0, ltu = 1'b0;

    logic        predTaken, cTransf, mispredict, brIllegal;
    logic [31:0] branchCnt, mispredCnt;
    logic        predTaken4, cTransf4, mispredict4, brIllegal4;
    logic [3:0]  branchCnt4, mispredCnt4;

    int passCnt = 0;
    int totalCnt = 0;
    bit cmpEn = 1'b0;

    // Behavioural model state: counter value per entry, plain integer event counts.
    int bhtM [16];
    int brM, mpM;
    bit misM, illM;

    branch_unit_bht #(.XLEN(32), .BHT_ENTRIES(16), .CNT_W(2), .PERF_W(32)) dut (
        .iCLK(clk), .iRST_n(rstN), .iFetchPC(fetchPc), .oPredTaken(predTaken),
        .iResolveValid(resolveValid), .iResolvePC(resolvePc), .iPredTaken(predIn),
        .iFunct3(funct3), .iCOrigPC(cOrigPc), .iZero(zero), .iLT(lt), .iLTU(ltu),
        .oCTransf(cTransf), .oMispredict(mispredict), .oBrIllegal(brIllegal),
        .oBranchCnt(branchCnt), .oMispredCnt(mispredCnt)
    );

    branch_unit_bht #(.XLEN(32), .BHT_ENTRIES(16), .CNT_W(2), .PERF_W(4)) dut4 (
        .iCLK(clk), .iRST_n(rstN), .iFetchPC(fetchPc), .oPredTaken(predTaken4),
        .iResolveValid(resolveValid), .iResolvePC(resolvePc), .iPredTaken(predIn),
        .iFunct3(funct3), .iCOrigPC(cOrigPc), .iZero(zero), .iLT(lt), .iLTU(ltu),
        .oCTransf(cTransf4), .oMispredict(mispredict4), .oBrIllegal(brIllegal4),
        .oBranchCnt(branchCnt4), .oMispredCnt(mispredCnt4)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        totalCnt++;
        if (act === exp) passCnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Branch rule from the ISA: funct3 picks the comparison; 2 and 3 never take.
    function automatic bit modelDecide(input int f3, input bit z, input bit l, input bit lu);
        if (f3 == 0) return z;
        if (f3 == 1) return !z;
        if (f3 == 4) return l;
        if (f3 == 5) return !l;
        if (f3 == 6) return lu;
        if (f3 == 7) return !lu;
        return 1'b0;
    endfunction

    function automatic int entryOf(input logic [31:0] pc);
        return int'(pc / 4) % 16;
    endfunction

    // Model update on each edge, or immediately on reset assertion.
    int mIdx;
    bit mOutcome;
    always @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            foreach (bhtM[i]) bhtM[i] = 1;
            brM = 0; mpM = 0; misM = 0; illM = 0;
        end else begin
            misM = 0; illM = 0;
            if (resolveValid && cOrigPc == 2'd1) begin
                if (funct3 == 3'd2 || funct3 == 3'd3) begin
                    illM = 1;
                end else begin
                    mOutcome = modelDecide(int'(funct3), zero, lt, ltu);
                    mIdx = entryOf(resolvePc);
                    bhtM[mIdx] = mOutcome ? ((bhtM[mIdx] < 3) ? bhtM[mIdx] + 1 : 3)
                                          : ((bhtM[mIdx] > 0) ? bhtM[mIdx] - 1 : 0);
                    brM++;
                    if (mOutcome != predIn) begin
                        misM = 1;
                        mpM++;
                    end
                end
            end
        end
    end

    // Compare process: every falling edge, all outputs of both instances against the model.
    bit expCt;
    always @(negedge clk) begin
        if (cmpEn) begin
            expCt = (cOrigPc == 2'd0) ? 1'b0 :
                    (cOrigPc == 2'd1) ? modelDecide(int'(funct3), zero, lt, ltu) : 1'b1;
            check("cyc_pred",      32'(predTaken),  32'(bhtM[entryOf(fetchPc)] >= 2));
            check("cyc_ctransf",   32'(cTransf),    32'(expCt));
            check("cyc_mispred",   32'(mispredict), 32'(misM));
            check("cyc_illegal",   32'(brIllegal),  32'(illM));
            check("cyc_brcnt",     branchCnt,       32'(brM));
            check("cyc_mpcnt",     mispredCnt,      32'(mpM));
            check("cyc_pred4",     32'(predTaken4), 32'(bhtM[entryOf(fetchPc)] >= 2));
            check("cyc_brcnt4",    32'(branchCnt4), 32'((brM > 15) ? 15 : brM));
            check("cyc_mpcnt4",    32'(mispredCnt4),32'((mpM > 15) ? 15 : mpM));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input bit v, input logic [1:0] orig, input logic [2:0] f3,
                         input bit z, input bit l, input bit lu,
                         input logic [31:0] pc, input bit pred);
        resolveValid = v; cOrigPc = orig; funct3 = f3;
        zero = z; lt = l; ltu = lu; resolvePc = pc; predIn = pred;
    endtask

    task automatic idle();
        drive(0, 2'd0, 3'd0, 0, 0, 0, 32'h0, 0);
    endtask

    task automatic doReset();
        @(posedge clk);
        #2 rstN = 1'b0;
        #1 rstN = 1'b1;
    endtask

    initial begin
        idle();
        fetchPc = 32'h40;
        @(posedge clk);
        #2;
        cmpEn = 1'b1;

        // 1: reset state, then a taken BEQ that was predicted not-taken.
        check("rst_pred", 32'(predTaken), 32'h0);
        check("rst_brcnt", branchCnt, 32'h0);
        check("rst_mpcnt", mispredCnt, 32'h0);
        rstN = 1'b1;
        drive(1, 2'd1, 3'b000, 1, 0, 0, 32'h40, 0);
        #1 check("beq_ctransf", 32'(cTransf), 32'h1);
        tick();
        idle();
        check("beq_mispred", 32'(mispredict), 32'h1);
        check("beq_mpcnt", mispredCnt, 32'h1);

        // 2: three taken BNEs saturate the entry, two not-taken bring it back below half.
        doReset();
        drive(1, 2'd1, 3'b001, 0, 0, 0, 32'h40, 0);
        tick();
        check("bne_pred_after1", 32'(predTaken), 32'h1);
        tick();
        tick();
        check("bne_brcnt3", branchCnt, 32'h3);
        drive(1, 2'd1, 3'b001, 1, 0, 0, 32'h40, 1);
        tick();
        check("bne_pred_from_sat", 32'(predTaken), 32'h1);
        tick();
        idle();
        check("bne_pred_weak", 32'(predTaken), 32'h0);
        check("bne_mpcnt5", mispredCnt, 32'h5);

        // 3: flag sweep, decision only.
        drive(0, 2'd1, 3'b100, 0, 1, 0, 32'h0, 0);
        #1 check("blt", 32'(cTransf), 32'h1);
        drive(0, 2'd1, 3'b110, 0, 1, 0, 32'h0, 0);
        #1 check("bltu", 32'(cTransf), 32'h0);
        drive(0, 2'd1, 3'b101, 0, 0, 0, 32'h0, 0);
        #1 check("bge", 32'(cTransf), 32'h1);
        drive(0, 2'd1, 3'b111, 0, 0, 1, 32'h0, 0);
        #1 check("bgeu", 32'(cTransf), 32'h0);

        // 4: jumps and an illegal branch leave the BHT and counters alone.
        tick();
        drive(1, 2'd2, 3'b000, 0, 0, 0, 32'h40, 0);
        #1 check("jal", 32'(cTransf), 32'h1);
        tick();
        drive(1, 2'd3, 3'b000, 0, 0, 0, 32'h40, 0);
        #1 check("jalr", 32'(cTransf), 32'h1);
        tick();
        drive(1, 2'd1, 3'b010, 1, 1, 1, 32'h40, 0);
        #1 check("illegal_ctransf", 32'(cTransf), 32'h0);
        tick();
        idle();
        check("illegal_pulse", 32'(brIllegal), 32'h1);
        check("jump_brcnt", branchCnt, 32'h5);
        check("jump_pred", 32'(predTaken), 32'h0);
        tick();
        check("illegal_pulse_end", 32'(brIllegal), 32'h0);

        // 5: same-cycle update and aliased lookup returns the old prediction.
        doReset();
        fetchPc = 32'h80;
        drive(1, 2'd1, 3'b001, 0, 0, 0, 32'h40, 0);
        #1 check("alias_old", 32'(predTaken), 32'h0);
        tick();
        idle();
        #1 check("alias_new", 32'(predTaken), 32'h1);

        // 6: asynchronous reset between edges, and no update while held in reset.
        drive(1, 2'd1, 3'b000, 0, 0, 0, 32'h44, 1);
        tick();
        check("pre_rst_mispred", 32'(mispredict), 32'h1);
        drive(1, 2'd1, 3'b001, 0, 0, 0, 32'h80, 0);
        #2 rstN = 1'b0;
        #1;
        check("async_pred", 32'(predTaken), 32'h0);
        check("async_mispred", 32'(mispredict), 32'h0);
        check("async_brcnt", branchCnt, 32'h0);
        tick();
        check("held_brcnt", branchCnt, 32'h0);
        check("held_pred", 32'(predTaken), 32'h0);
        rstN = 1'b1;
        idle();

        // Performance counter saturation in the 4-bit build.
        doReset();
        drive(1, 2'd1, 3'b001, 0, 0, 0, 32'h100, 0);
        repeat (20) tick();
        idle();
        check("perf32_br", branchCnt, 32'd20);
        check("perf4_br_sat", 32'(branchCnt4), 32'd15);
        check("perf4_mp_sat", 32'(mispredCnt4), 32'd15);

        // Random traffic against the model, with one asynchronous reset in the middle.
        for (int i = 0; i < 400; i++) begin
            tick();
            resolveValid = ($urandom_range(3) != 0);
            cOrigPc = ($urandom_range(4) < 3) ? 2'd1 : 2'($urandom_range(3));
            funct3 = 3'($urandom_range(7));
            zero = 1'($urandom); lt = 1'($urandom); ltu = 1'($urandom);
            predIn = 1'($urandom);
            resolvePc = $urandom;
            fetchPc = ($urandom_range(3) == 0) ? resolvePc : $urandom;
            if (i == 200) begin
                #1 rstN = 1'b0;
                #1 rstN = 1'b1;
            end
        end
        tick();
        idle();
        tick();
        cmpEn = 1'b0;

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
